core_avm_burst_writer: RTL and testbench
========================================

Name: core_avm_burst_writer

Overview:
- Avalon-MM burst-write initiator for the core's FPGA-side master write port (avm_tx_*), which is currently tied off.
- Local logic, e.g. CSR-triggered dump of CPU data, pushes 32-bit words into an internal show-ahead FIFO.
- On a start command the block issues the words as back-to-back Avalon write bursts to a programmed byte address.
- It is the write-direction counterpart of the CSR responder and is the block that will drive the top level's avm_tx_* master.

Parameters:
- FIFO_LOG2_DEPTH, 5, log2 of FIFO depth in 32-bit words (32).
- MAX_BURST, 16, maximum beats per burst; must be >= 1 and <= 2**FIFO_LOG2_DEPTH.
- LEN_WIDTH, 16, width of the transfer length in words.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle transfer request
- base_addr  input  32  byte start address, latched on accepted start; bits [1:0] ignored and treated as 0
- length  input  LEN_WIDTH  transfer length in 32-bit words, latched on accepted start
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at transfer completion
- wr_valid  input  1  local data word valid
- wr_data  input  32  local data word
- wr_ready  output  1  FIFO not full; a word is pushed when wr_valid & wr_ready
- fifo_level  output  FIFO_LOG2_DEPTH+1  current FIFO occupancy
- avm_tx_waitrequest  input  1  Avalon waitrequest
- avm_tx_burstcount  output  12  beats in the current burst
- avm_tx_address  output  32  byte address of the current burst
- avm_tx_write  output  1  write strobe
- avm_tx_writedata  output  32  write data (FIFO head)

Behaviour:

Reset values (async on rst): busy=0, done=0, avm_tx_write=0, avm_tx_burstcount=0, avm_tx_address=0, avm_tx_writedata=0, fifo_level=0, wr_ready=1. FIFO is emptied and the FSM is in IDLE. Reset mid-burst abandons the burst immediately; no completion pulse is produced.

FIFO:
- Pushes are accepted in any state, so the FIFO can be pre-filled before start.
- Push and pop in the same cycle leave the level unchanged.
- When full, wr_ready=0 and no push occurs, even if a pop happens in the same cycle.
- fifo_level is registered and exact.

FSM states: IDLE, WAIT_DATA, BURST, DONE.
- IDLE -> WAIT_DATA on start=1, with base_addr and length latched and busy=1 from the next cycle.
  - If length==0, go IDLE -> DONE instead.
  - start is ignored in every state other than IDLE.
- WAIT_DATA:
  - Compute blen = min(MAX_BURST, remaining).
  - Stay in WAIT_DATA while fifo_level < blen.
  - Once fifo_level >= blen, enter BURST with avm_tx_write=1, avm_tx_burstcount=blen and avm_tx_address=current address, all registered.
- BURST:
  - A beat is accepted when avm_tx_write & ~avm_tx_waitrequest; each accepted beat pops the FIFO.
  - avm_tx_writedata is always the FIFO head while write=1, and 0 while write=0.
  - avm_tx_write stays high for every beat without gaps, since the data is guaranteed present.
  - burstcount and address are held stable for the whole burst.
  - On the last beat accepted:
    - remaining -= blen and address += 4*blen, with 32-bit wraparound.
    - avm_tx_write drops in the next cycle.
    - If remaining==0, go to DONE; otherwise go to WAIT_DATA.
  - At least one idle cycle separates consecutive bursts.
- DONE: done=1 for exactly one cycle and busy=0 in that same cycle, then IDLE.
- Latency: with a pre-filled FIFO, avm_tx_write first rises 2 cycles after start is sampled.
- Any length is valid. The final burst is shortened to the remainder; for example, length=37 with MAX_BURST=16 gives bursts of 16, 16 and 5.
- waitrequest may be held high indefinitely, and all outputs stay stable while it is.

Test Plan:
- Prefill 16 words 0x100..0x10F, then start with base_addr=0x2000_0000, length=16, waitrequest=0 -> one burst, burstcount=16, address=0x2000_0000, data 0x100..0x10F on 16 consecutive cycles, then a done pulse and fifo_level=0.
- length=37, MAX_BURST=16, data streamed at 1 word per 3 cycles -> bursts of 16/16/5 at 0x0, 0x40, 0x80; write never asserted before the FIFO holds the full blen; done pulses once.
- Random waitrequest (50%) during a 16-beat burst -> address, burstcount and writedata held while waitrequest=1; exactly 16 accepted beats; data order preserved.
- Push 32 words with no start -> wr_ready=0 and fifo_level=32; a 33rd wr_valid is not accepted; a subsequent start with length=32 drains the FIFO correctly.
- start with length=0 -> no avm_tx_write, done pulses one cycle later; a second start pulsed while busy during a 16-word transfer is ignored.
- Assert rst mid-burst (beat 5 of 16) -> avm_tx_write=0, busy=0 and fifo_level=0 immediately; a following start with length=4 and fresh data completes normally.

Source files
------------

// File: rtl/core_avm_burst_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : core_avm_burst_writer_if
// Description : Avalon-MM burst-write bus (avm_tx_*) between the burst writer
//               (master) and the fabric / memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface core_avm_burst_writer_if;
  logic        waitrequest;
  logic [11:0] burstcount;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;

  modport master (
    input  waitrequest,
    output burstcount,
    output address,
    output write,
    output writedata
  );

  modport slave (
    output waitrequest,
    input  burstcount,
    input  address,
    input  write,
    input  writedata
  );
endinterface
`default_nettype wire

// File: rtl/core_avm_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : core_avm_burst_writer
// Description : Avalon-MM burst-write initiator. Local logic fills a
//               show-ahead FIFO; a start command drains `length` words as
//               back-to-back bursts of up to MAX_BURST beats to base_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module core_avm_burst_writer #(
  parameter int FIFO_LOG2_DEPTH = 5,
  parameter int MAX_BURST       = 16,
  parameter int LEN_WIDTH       = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       start,
  input  wire logic [31:0]                base_addr,
  input  wire logic [LEN_WIDTH-1:0]       length,
  output logic                            busy,
  output logic                            done,
  input  wire logic                       wr_valid,
  input  wire logic [31:0]                wr_data,
  output logic                            wr_ready,
  output logic [FIFO_LOG2_DEPTH:0]        fifo_level,
  core_avm_burst_writer_if.master         avm_tx
);

  localparam int DEPTH = 2 ** FIFO_LOG2_DEPTH;
  localparam logic [FIFO_LOG2_DEPTH:0] FULL_LEVEL = (FIFO_LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LEN_WIDTH-1:0]     MAX_LEN    = LEN_WIDTH'(MAX_BURST);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_DATA = 2'd1;
  localparam logic [1:0] S_BURST     = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  // Byte-lane bits of the start address are forced to zero and otherwise unused.
  wire unused_base_lsbs = &{1'b0, base_addr[1:0]};

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [31:0]                mem [DEPTH];
  logic [FIFO_LOG2_DEPTH-1:0] wr_ptr;
  logic [FIFO_LOG2_DEPTH-1:0] rd_ptr;
  logic [31:0]                head;
  logic                       push;
  logic                       pop;

  logic [1:0]                 state;
  logic [1:0]                 state_next;
  logic [LEN_WIDTH-1:0]       rem;
  logic [LEN_WIDTH-1:0]       blen;
  logic [LEN_WIDTH-1:0]       blen_q;
  logic [LEN_WIDTH-1:0]       beats_left;
  logic [31:0]                addr;
  logic                       data_ready;
  logic                       last_beat;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign wr_ready = (fifo_level != FULL_LEVEL);
  assign push     = wr_valid & wr_ready;
  assign pop      = (state == S_BURST) & ~avm_tx.waitrequest;
  assign head     = mem[rd_ptr];

  // Storage array, written on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and exact occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Burst sequencing
  // --------------------------------------------------------------------------
  // Size of the next burst and whether the FIFO already holds all of it.
  always_comb begin
    blen       = (rem < MAX_LEN) ? rem : MAX_LEN;
    data_ready = (32'(fifo_level) >= 32'(blen));
    last_beat  = pop & (beats_left == LEN_WIDTH'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? S_DONE : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (data_ready) state_next = S_BURST;
      end
      S_BURST: begin
        if (last_beat) begin
          state_next = (rem == blen_q) ? S_DONE : S_WAIT_DATA;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping: remaining words, current address, burst size and beat count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      addr       <= '0;
      blen_q     <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem  <= length;
            addr <= {base_addr[31:2], 2'b00};
          end
        end
        S_WAIT_DATA: begin
          if (data_ready) begin
            blen_q     <= blen;
            beats_left <= blen;
          end
        end
        S_BURST: begin
          if (pop) begin
            beats_left <= beats_left - 1'b1;
          end
          if (last_beat) begin
            rem  <= rem - blen_q;
            addr <= addr + (32'(blen_q) << 2);
          end
        end
        default: ;
      endcase
    end
  end

  // Status and bus outputs; data is the FIFO head only while the strobe is up.
  always_comb begin
    busy               = 1'b0;
    done               = 1'b0;
    avm_tx.write       = 1'b0;
    avm_tx.writedata   = '0;
    avm_tx.burstcount  = 12'(blen_q);
    avm_tx.address     = addr;
    case (state)
      S_WAIT_DATA: busy = 1'b1;
      S_BURST: begin
        busy             = 1'b1;
        avm_tx.write     = 1'b1;
        avm_tx.writedata = head;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_core_avm_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_avm_burst_writer
// Description : Self-checking bench for core_avm_burst_writer with a
//               transaction-level reference model (word queue + burst plan).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_avm_burst_writer;
  localparam int LOG2 = 5;
  localparam int MB   = 16;
  localparam int LW   = 16;
  localparam int DEP  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy;
  logic          done;
  logic          wr_valid = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_ready;
  logic [LOG2:0] fifo_level;

  core_avm_burst_writer_if avm_tx();

  core_avm_burst_writer #(
    .FIFO_LOG2_DEPTH (LOG2),
    .MAX_BURST       (MB),
    .LEN_WIDTH       (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_level (fifo_level),
    .avm_tx     (avm_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  logic [31:0] q[$];
  burst_t      plan_q[$];
  bit          m_write, m_busy, m_done;
  int          beats;
  int          nbursts = 0;
  int          acc_cnt = 0;
  bit          prev_write = 1'b0;

  // Split a transfer into bursts purely arithmetically.
  task automatic make_plan(input logic [31:0] base, input int len);
    logic [31:0] a;
    int          r;
    int          b;
    a = base & 32'hFFFF_FFFC;
    r = len;
    while (r > 0) begin
      b = (r < MB) ? r : MB;
      plan_q.push_back('{a, b});
      a = a + 32'(b * 4);
      r = r - b;
    end
  endtask

  // Compare DUT against model, then advance model to the next clock edge.
  always @(negedge clk) begin
    bit n_write, n_busy, n_done, acc, psh;
    if (rst) begin
      q.delete();
      plan_q.delete();
      m_write = 0; m_busy = 0; m_done = 0; beats = 0;
      prev_write = 0;
    end else begin
      check("level", fifo_level, q.size());
      check("wr_ready", wr_ready, (q.size() < DEP));
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("write", avm_tx.write, m_write);
      if (m_write && plan_q.size() > 0 && q.size() > 0) begin
        check("burstcount", avm_tx.burstcount, plan_q[0].len);
        check("address", avm_tx.address, plan_q[0].addr);
        check("writedata", avm_tx.writedata, q[0]);
      end else if (!m_write) begin
        check("writedata_idle", avm_tx.writedata, 0);
      end
      if (avm_tx.write && !prev_write) nbursts++;
      prev_write = avm_tx.write;
      if (avm_tx.write && !avm_tx.waitrequest) acc_cnt++;

      n_write = m_write; n_busy = m_busy; n_done = 0;
      acc = m_write && !avm_tx.waitrequest;
      psh = wr_valid && (q.size() < DEP);
      if (!m_busy && !m_done && start) begin
        if (length == 0) n_done = 1;
        else begin
          make_plan(base_addr, int'(length));
          n_busy = 1;
        end
      end
      if (m_busy && !m_write && plan_q.size() > 0 && q.size() >= plan_q[0].len) begin
        n_write = 1;
        beats   = 0;
      end
      if (acc) begin
        void'(q.pop_front());
        beats++;
        if (plan_q.size() > 0 && beats == plan_q[0].len) begin
          n_write = 0;
          plan_q.delete(0);
          if (plan_q.size() == 0) begin
            n_busy = 0;
            n_done = 1;
          end
        end
      end
      if (psh) q.push_back(wr_data);
      m_write = n_write; m_busy = n_busy; m_done = n_done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input int len);
    base_addr = a;
    length    = LW'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [31:0] first, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = rnd ? $urandom : first + 32'(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    check(name, seen, 1);
  endtask

  initial begin
    bit seen;
    avm_tx.waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", avm_tx.write, 0);
    check("rst_burstcount", avm_tx.burstcount, 0);
    check("rst_address", avm_tx.address, 0);
    check("rst_writedata", avm_tx.writedata, 0);
    check("rst_level", fifo_level, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;
    step();

    // Prefilled single 16-beat burst, latency pinned.
    push_words(16, 32'h100, 0);
    check("t1_prefill_level", fifo_level, 16);
    pulse_start(32'h2000_0000, 16);
    check("t1_no_write_yet", avm_tx.write, 0);
    step();
    check("t1_write_rise", avm_tx.write, 1);
    check("t1_burstcount", avm_tx.burstcount, 16);
    check("t1_address", avm_tx.address, 32'h2000_0000);
    check("t1_data0", avm_tx.writedata, 32'h100);
    wait_done("t1_done", 100);
    check("t1_level_empty", fifo_level, 0);
    step();

    // 37 words trickled in: bursts 16/16/5.
    nbursts = 0;
    pulse_start(32'h0, 37);
    for (int i = 0; i < 37; i++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      step();
      wr_valid = 1'b0;
      step();
      step();
    end
    wait_done("t2_done", 200);
    check("t2_bursts", nbursts, 3);
    check("t2_next_addr", avm_tx.address, 32'h94);
    step();

    // Random waitrequest during a 16-beat burst.
    acc_cnt = 0;
    push_words(16, 0, 1);
    pulse_start($urandom, 16);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      avm_tx.waitrequest = 1'($urandom_range(0, 1));
      step();
      if (done === 1'b1) seen = 1;
    end
    avm_tx.waitrequest = 1'b0;
    check("t3_done", seen, 1);
    check("t3_beats", acc_cnt, 16);
    step();

    // Fill to full, extra word rejected, then drain 32.
    push_words(33, 0, 1);
    check("t4_wr_ready_full", wr_ready, 0);
    check("t4_level_full", fifo_level, 32);
    pulse_start(32'h1000_0000, 32);
    wait_done("t4_done", 200);
    check("t4_level_empty", fifo_level, 0);
    step();

    // Zero length, then a start while busy is ignored.
    pulse_start(32'h0, 0);
    check("t5_zero_done", done, 1);
    check("t5_zero_write", avm_tx.write, 0);
    step();
    check("t5_done_once", done, 0);
    nbursts = 0;
    pulse_start(32'h300, 16);
    step();
    pulse_start(32'h900, 5);
    push_words(16, 32'h500, 0);
    wait_done("t5_done", 100);
    check("t5_bursts", nbursts, 1);
    step();

    // Reset in the middle of a burst, then a clean 4-word transfer.
    push_words(16, 32'h600, 0);
    pulse_start(32'h4000, 16);
    step();
    repeat (4) step();
    check("t6_beat5_data", avm_tx.writedata, 32'h604);
    rst = 1'b1;
    #1;
    check("t6_rst_write", avm_tx.write, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_level", fifo_level, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    push_words(4, 32'h700, 0);
    pulse_start(32'h5000, 4);
    step();
    check("t6_burstcount", avm_tx.burstcount, 4);
    check("t6_address", avm_tx.address, 32'h5000);
    wait_done("t6_done", 50);
    check("t6_level_empty", fifo_level, 0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
